// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the Rtypeinst datapath.
// Latency: R-type 4, LW 5, SW 4, BEQ/CALL/RET 3 cycles from FETCH to pc_en; HALT/illegal opcodes park in HALTED/FAULT.
// Backpressure: none; the datapath is assumed to complete each step in one cycle, and reset aborts any instruction in flight.
// Ports: clk/reset (sync, active-high); op/zero from datapath; RegDst..PCSrc, ALUOp,
//   push/pop, pc_en datapath controls; state, sp_depth, halted, fault status.
module multicycle_ctrl #(
  parameter int STACK_DEPTH = 16,
  parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    op,
  input  logic          zero,
  output logic          RegDst,
  output logic          ALUSrc,
  output logic          Mem2Reg,
  output logic          MemRead,
  output logic          MemWrite,
  output logic          RegWrite,
  output logic          PCSrc,
  output logic [4:0]    ALUOp,
  output logic          push,
  output logic          pop,
  output logic          pc_en,
  output logic [2:0]    state,
  output logic [DW-1:0] sp_depth,
  output logic          halted,
  output logic          fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_CALL  = 6'b000011;
  localparam logic [5:0] OP_RET   = 6'b000111;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

  state_t     state_q, state_d;
  logic [5:0] ir_op;

  assign state = state_q;

  // State, opcode register, stack depth and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_op    <= 6'd0;
      sp_depth <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) ir_op <= op;
      // Guards are redundant with the DECODE overflow checks; they keep
      // the counter from wrapping even if that invariant were broken.
      if (push && sp_depth != DEPTH_FULL)   sp_depth <= sp_depth + DW'(1);
      else if (pop && sp_depth != '0)       sp_depth <= sp_depth - DW'(1);
      if (state_d == S_HALTED) halted <= 1'b1;
      if (state_d == S_FAULT)  fault  <= 1'b1;
    end
  end

  // Next state and control decode. Controls are gated off during reset so
  // an aborted instruction never issues a strobe in the reset cycle.
  always_comb begin
    state_d  = state_q;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    Mem2Reg  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    PCSrc    = 1'b0;
    ALUOp    = 5'd0;
    push     = 1'b0;
    pop      = 1'b0;
    pc_en    = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ir_op)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          OP_CALL: state_d = (sp_depth == DEPTH_FULL) ? S_FAULT : S_EXEC;
          OP_RET:  state_d = (sp_depth == '0)         ? S_FAULT : S_EXEC;
          OP_HALT: state_d = S_HALTED;
          default: state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (ir_op)
          OP_RTYPE: begin
            state_d = S_WB;
            ALUOp   = 5'd2;
            RegDst  = 1'b1;
          end
          OP_LW: begin
            state_d = S_MEM;
            ALUSrc  = 1'b1;
          end
          OP_SW: begin
            state_d = S_MEM;
            ALUSrc  = 1'b1;
          end
          OP_BEQ: begin
            state_d = S_FETCH;
            ALUOp   = 5'd1;
            PCSrc   = zero;
            pc_en   = 1'b1;
          end
          OP_CALL: begin
            state_d = S_FETCH;
            push    = 1'b1;
            PCSrc   = 1'b1;
            pc_en   = 1'b1;
          end
          OP_RET: begin
            state_d = S_FETCH;
            pop     = 1'b1;
            PCSrc   = 1'b1;
            pc_en   = 1'b1;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        ALUSrc = 1'b1;
        if (ir_op == OP_LW) begin
          state_d = S_WB;
          MemRead = 1'b1;
        end else begin
          state_d  = S_FETCH;
          MemWrite = 1'b1;
          pc_en    = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        if (ir_op == OP_LW) begin
          ALUSrc   = 1'b1;
          MemRead  = 1'b1;
          Mem2Reg  = 1'b1;
          RegWrite = 1'b1;
          pc_en    = 1'b1;
        end else begin
          ALUOp    = 5'd2;
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          pc_en    = 1'b1;
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase

    if (reset) begin
      RegDst   = 1'b0;
      ALUSrc   = 1'b0;
      Mem2Reg  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      PCSrc    = 1'b0;
      ALUOp    = 5'd0;
      push     = 1'b0;
      pop      = 1'b0;
      pc_en    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl.
// Walks each instruction class cycle by cycle against hand-computed control vectors.
// Control vector order: {RegDst,ALUSrc,Mem2Reg,MemRead,MemWrite,RegWrite,PCSrc,push,pop,pc_en}.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc;
  logic [4:0] ALUOp;
  logic       push, pop, pc_en;
  logic [2:0] state;
  logic [4:0] sp_depth;
  logic       halted, fault;
  logic [9:0] ctl;

  int n_pass  = 0;
  int n_total = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .push(push), .pop(pop), .pc_en(pc_en), .state(state),
    .sp_depth(sp_depth), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign ctl = {RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc, push, pop, pc_en};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle's state/controls/ALUOp, then advance to the next cycle.
  task automatic cyc(input string tag, input int st, input int c, input int a);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctl"},   32'(ctl),   32'(c));
    chk({tag, ".aluop"}, 32'(ALUOp), 32'(a));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk("rst.ctl", 32'(ctl), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'd0;
    zero  = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst.state",  32'(state), 0);
    chk("rst.ctl0",   32'(ctl), 0);
    chk("rst.aluop",  32'(ALUOp), 0);
    chk("rst.depth",  32'(sp_depth), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.fault",  32'(fault), 0);
    reset = 1'b0;

    // R-type; op changes after FETCH must not affect decode
    op = 6'd0;
    cyc("r.fetch", 0, 0, 0);
    op = 6'd35;
    cyc("r.dec",  1, 0, 0);
    cyc("r.exec", 2, 'b1000000000, 2);
    cyc("r.wb",   4, 'b1000010001, 2);
    chk("r.next", 32'(state), 0);

    // LW
    op = 6'd35;
    cyc("lw.fetch", 0, 0, 0);
    cyc("lw.dec",   1, 0, 0);
    cyc("lw.exec",  2, 'b0100000000, 0);
    cyc("lw.mem",   3, 'b0101000000, 0);
    cyc("lw.wb",    4, 'b0111010001, 0);

    // SW
    op = 6'd43;
    cyc("sw.fetch", 0, 0, 0);
    cyc("sw.dec",   1, 0, 0);
    cyc("sw.exec",  2, 'b0100000000, 0);
    cyc("sw.mem",   3, 'b0100100001, 0);

    // BEQ taken, then not taken; PCSrc follows zero inside EXEC
    op = 6'd4;
    zero = 1'b1;
    cyc("beq1.fetch", 0, 0, 0);
    cyc("beq1.dec",   1, 0, 0);
    chk("beq1.pcsrc_z1", 32'(PCSrc), 1);
    zero = 1'b0;
    #1;
    chk("beq1.pcsrc_z0", 32'(PCSrc), 0);
    zero = 1'b1;
    #1;
    cyc("beq1.exec",  2, 'b0000001001, 1);
    zero = 1'b0;
    cyc("beq0.fetch", 0, 0, 0);
    cyc("beq0.dec",   1, 0, 0);
    cyc("beq0.exec",  2, 'b0000000001, 1);
    chk("beq0.next", 32'(state), 0);

    // 16 CALLs fill the stack, the 17th faults without a push
    op = 6'd3;
    for (int i = 0; i < 16; i++) begin
      cyc("call.fetch", 0, 0, 0);
      cyc("call.dec",   1, 0, 0);
      cyc("call.exec",  2, 'b0000001101, 0);
      chk("call.depth", 32'(sp_depth), 32'(i + 1));
    end
    cyc("call17.fetch", 0, 0, 0);
    cyc("call17.dec",   1, 0, 0);
    chk("call17.fault", 32'(fault), 1);
    cyc("call17.st6",   6, 0, 0);
    cyc("call17.hold",  6, 0, 0);
    chk("call17.depth", 32'(sp_depth), 16);
    do_reset();
    chk("rst2.depth", 32'(sp_depth), 0);
    chk("rst2.fault", 32'(fault), 0);
    chk("rst2.state", 32'(state), 0);

    // CALL, RET, RET (second RET underflows)
    op = 6'd3;
    cyc("c.fetch", 0, 0, 0);
    cyc("c.dec",   1, 0, 0);
    cyc("c.exec",  2, 'b0000001101, 0);
    chk("c.depth", 32'(sp_depth), 1);
    op = 6'd7;
    cyc("ret.fetch", 0, 0, 0);
    cyc("ret.dec",   1, 0, 0);
    cyc("ret.exec",  2, 'b0000001011, 0);
    chk("ret.depth", 32'(sp_depth), 0);
    cyc("ret2.fetch", 0, 0, 0);
    cyc("ret2.dec",   1, 0, 0);
    cyc("ret2.st6",   6, 0, 0);
    chk("ret2.fault", 32'(fault), 1);
    chk("ret2.depth", 32'(sp_depth), 0);
    do_reset();

    // HALT
    op = 6'd63;
    cyc("halt.fetch", 0, 0, 0);
    cyc("halt.dec",   1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("halt.flag", 32'(halted), 1);
      cyc("halt.hold", 5, 0, 0);
    end
    chk("halt.nofault", 32'(fault), 0);
    do_reset();
    chk("rst3.halted", 32'(halted), 0);

    // Illegal opcode
    op = 6'd5;
    cyc("ill.fetch", 0, 0, 0);
    cyc("ill.dec",   1, 0, 0);
    cyc("ill.st6",   6, 0, 0);
    chk("ill.fault",  32'(fault), 1);
    chk("ill.halted", 32'(halted), 0);
    do_reset();

    // Reset during SW MEM cycle suppresses MemWrite
    op = 6'd43;
    cyc("swr.fetch", 0, 0, 0);
    cyc("swr.dec",   1, 0, 0);
    cyc("swr.exec",  2, 'b0100000000, 0);
    chk("swr.mem_state", 32'(state), 3);
    reset = 1'b1;
    #1;
    chk("swr.memwrite", 32'(MemWrite), 0);
    chk("swr.pc_en",    32'(pc_en), 0);
    tick();
    reset = 1'b0;
    cyc("swr.after", 0, 0, 0);
    cyc("swr.dec2",  1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
